micro_prog_loader: RTL and testbench

//  Upstream program-load stage for the 4-opcode micro core. Receives a framed byte stream,

---
 rtl/micro_prog_loader.sv | 135 +++++++++++++
 tb/tb_micro_prog_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/micro_prog_loader.sv
// Framed byte-stream program loader: fills instruction RAM and holds the core in reset until RUN.
// Optional MICRO_LOADER_CSUM_EN adds a trailing checksum byte and the sticky load_err flag.
module micro_prog_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INST_W   = 13,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned HiW   = INST_W - 8;

  typedef enum logic [2:0] {StIdle, StCnt, StHi, StLo, StCsum, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [HiW-1:0]    hi_q, hi_d;
  logic              core_rst_q, load_done_q;
  logic              xfer, we, csum_ok;
  logic [INST_W-1:0] mem [Depth];

  assign in_ready = ~reset;
  assign xfer     = in_valid & in_ready;

`ifdef MICRO_LOADER_CSUM_EN
  localparam state_e AfterLast = StCsum;

  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;

  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (xfer) begin
      case (state_q)
        StCnt:               sum_d = in_data;
        StHi, StLo:          sum_d = sum_q + in_data;
        StCsum:              if (in_data != sum_q) err_d = 1'b1;
        StIdle, StRun, StErr: if (in_data == HDR_BYTE) err_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign csum_ok  = (in_data == sum_q);
  assign load_err = err_q;
`else
  localparam state_e AfterLast = StRun;

  assign csum_ok  = 1'b1;
  assign load_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    hi_d    = hi_q;
    we      = 1'b0;
    if (xfer) begin
      case (state_q)
        StIdle: if (in_data == HDR_BYTE) state_d = StCnt;
        StCnt: begin
          // A zero count stands for a full RAM image.
          count_d = (in_data == 8'd0) ? (ADDR_W + 1)'(Depth) : (ADDR_W + 1)'(in_data);
          words_d = '0;
          state_d = StHi;
        end
        StHi: begin
          hi_d    = in_data[HiW-1:0];
          state_d = StLo;
        end
        StLo: begin
          we      = 1'b1;
          words_d = words_q + 1'b1;
          state_d = (words_d == count_q) ? AfterLast : StHi;
        end
        StCsum:       state_d = csum_ok ? StRun : StErr;
        StRun, StErr: if (in_data == HDR_BYTE) state_d = StCnt;
        default:      state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      words_q     <= '0;
      hi_q        <= '0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      words_q     <= words_d;
      hi_q        <= hi_d;
      core_rst_q  <= (state_d != StRun);
      load_done_q <= (state_d == StRun);
    end
  end

  // RAM has no reset so a loaded program survives a core/loader reset.
  always_ff @(posedge clk) begin
    if (we) mem[words_q[ADDR_W-1:0]] <= {hi_q, in_data};
  end

  assign inst      = mem[pc];
  assign core_rst  = core_rst_q;
  assign load_done = load_done_q;
  assign words     = words_q;

endmodule

// File: tb/tb_micro_prog_loader.sv
// Randomized self-checking bench for micro_prog_loader against a frame-level RAM/flag model.
// Honours MICRO_LOADER_CSUM_EN the same way as the design.
module tb_micro_prog_loader;

  localparam int AW    = 8;
  localparam int IW    = 13;
  localparam int DEPTH = 256;
`ifdef MICRO_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] pc;
  logic [IW-1:0] inst;
  logic          core_rst, load_done, load_err;
  logic [AW:0]   words;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IW-1:0] ref_mem [DEPTH];
  logic [IW-1:0] fw      [DEPTH];

  always #5 clk = ~clk;

  micro_prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc        (pc),
    .inst      (inst),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err),
    .words     (words)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random idle gaps with junk data on a deasserted valid, then one transfer.
  task automatic put(input logic [7:0] b);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic peek(input int a, input string tag);
    pc = AW'(a);
    #1;
    check(tag, 32'(inst), 32'(ref_mem[a]));
  endtask

  task automatic check_all();
    for (int a = 0; a < DEPTH; a++) peek(a, "ram_dump");
  endtask

  // Sends fw[0..n-1] as one frame; bad corrupts the checksum when one is sent.
  task automatic send_frame(input int n, input bit bad);
    logic [7:0] sum, hi, lo;
    bit ok;
    ok = !(CsumEn && bad);
    put(8'hA5);
    check("hdr_core_rst", 32'(core_rst), 32'd1);
    check("hdr_load_done", 32'(load_done), 32'd0);
    check("hdr_load_err", 32'(load_err), 32'd0);
    sum = 8'(n);
    put(8'(n));
    for (int i = 0; i < n; i++) begin
      hi  = {3'($urandom), fw[i][12:8]};
      lo  = fw[i][7:0];
      sum = sum + hi + lo;
      put(hi);
      check("mid_core_rst", 32'(core_rst), 32'd1);
      put(lo);
      ref_mem[i] = fw[i];
      peek(i, "inst_after_lo");
    end
    if (CsumEn) put(bad ? sum + 8'd1 : sum);
    check("end_core_rst", 32'(core_rst), 32'(!ok));
    check("end_load_done", 32'(load_done), 32'(ok));
    check("end_load_err", 32'(load_err), 32'(CsumEn && !ok));
    check("end_words", 32'(words), 32'(n));
  endtask

  task automatic send_scen1();
    put(8'hA5); put(8'h02); put(8'h01); put(8'h00); put(8'h1D); put(8'h0D);
    check("s1_rst_before_csum", 32'(core_rst), 32'(CsumEn));
    if (CsumEn) put(8'h2D);
    ref_mem[0] = 13'h0100;
    ref_mem[1] = 13'h1D0D;
    check("s1_core_rst", 32'(core_rst), 32'd0);
    check("s1_load_done", 32'(load_done), 32'd1);
    check("s1_words", 32'(words), 32'd2);
    pc = 8'd0;
    #1;
    check("s1_ram0", 32'(inst), 32'h0100);
    pc = 8'd1;
    #1;
    check("s1_ram1", 32'(inst), 32'h1D0D);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    pc       = '0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    send_scen1();

    // Bad checksum then a good frame.
    for (int i = 0; i < 2; i++) fw[i] = IW'($urandom);
    send_frame(2, 1'b1);
    for (int i = 0; i < 3; i++) fw[i] = IW'($urandom);
    send_frame(3, 1'b0);

    // Full-depth frame with RAM[i] = i.
    for (int i = 0; i < DEPTH; i++) fw[i] = IW'(i);
    send_frame(DEPTH, 1'b0);
    pc = 8'hFF;
    #1;
    check("full_ram255", 32'(inst), 32'h00FF);
    check_all();

    // Reload from RUN: only the first three words change.
    for (int i = 0; i < 3; i++) fw[i] = IW'($urandom);
    send_frame(3, 1'b0);
    check_all();

    // Reset after the HI of word 1.
    fw[0] = IW'($urandom);
    put(8'hA5); put(8'h02);
    put({3'b0, fw[0][12:8]}); put(fw[0][7:0]);
    ref_mem[0] = fw[0];
    put(8'h1F);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check("mid_rst_load_done", 32'(load_done), 32'd0);
    check("mid_rst_words", 32'(words), 32'd0);
    reset = 1'b0;
    peek(0, "mid_rst_ram0");
    peek(1, "mid_rst_ram1");

    // Non-header bytes in IDLE are dropped.
    put(8'h00);
    put(8'hFF);
    check("idle_drop_core_rst", 32'(core_rst), 32'd1);
    check("idle_drop_done", 32'(load_done), 32'd0);
    check("idle_drop_words", 32'(words), 32'd0);
    send_scen1();
    check_all();

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) fw[i] = IW'($urandom);
      send_frame(n, 1'($urandom_range(0, 1)));
      // Idle bytes in RUN/ERR are dropped.
      put(8'h3C);
      check("rand_words_hold", 32'(words), 32'(n));
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
